// File: rtl/joy_shift_port.sv
// joy_shift_port
//   CPU-side joypad port. The raw pressed-button vector from the controller
//   scanner is debounced into a stable copy (held). The CPU reads that copy
//   through an NES-style strobe/serial interface: write 1 then 0 to the strobe
//   register to latch, then read one bit per rd pulse, LSB (B) first. Reads
//   beyond the last button return FILL_BIT.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   buttons     raw pressed vector (1=pressed), bit0=B ... bit11=R
//   strobe_wr   1-cycle CPU write pulse to the strobe register
//   strobe_din  data bit written with strobe_wr
//   rd          1-cycle CPU read pulse of the serial port
//   serial_out  current serial bit (registered), sampled by the CPU during rd
//   held        debounced button state
//   changed     1-cycle pulse when held takes a new, different value

module joy_shift_port #(
  parameter int   NBUTTONS      = 12,
  parameter int   STABLE_CYCLES = 16,
  parameter logic FILL_BIT      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NBUTTONS-1:0] buttons,
  input  logic                strobe_wr,
  input  logic                strobe_din,
  input  logic                rd,
  output logic                serial_out,
  output logic [NBUTTONS-1:0] held,
  output logic                changed
);

  // Counter must hold STABLE_CYCLES-1; keep at least one bit so that
  // STABLE_CYCLES=1 still elaborates.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [NBUTTONS-1:0] cand;
  logic [CNT_W-1:0]    cnt;
  logic                strb;
  logic [NBUTTONS-1:0] shreg;
  logic [NBUTTONS-1:0] shreg_next;
  logic                match;
  logic                load;

  assign match = (buttons == cand);
  // Once the candidate has been stable long enough, held tracks it every
  // cycle; the counter stays saturated until the input moves again.
  assign load  = match && (cnt == CNT_MAX);

  // Debounce: restart the stability count on any input change, otherwise
  // count up to the threshold and then publish the candidate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand    <= '0;
      cnt     <= '0;
      held    <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (!match) begin
        cand <= buttons;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        held    <= cand;
        changed <= (cand != held);
      end
    end
  end

  // Next shift-register contents. A strobe write always reloads and wins over
  // a coincident read; while the strobe level is high the register is
  // transparent to held, so reads cannot advance it.
  always_comb begin
    shreg_next = shreg;
    if (strobe_wr) begin
      shreg_next = held;
    end else if (strb) begin
      shreg_next = held;
    end else if (rd) begin
      shreg_next = {FILL_BIT, shreg[NBUTTONS-1:1]};
    end
  end

  // Strobe level register, shift register and the registered serial bit.
  // serial_out mirrors the next LSB so the CPU sees the new bit in the cycle
  // after a shift, ready for its next rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb       <= 1'b0;
      shreg      <= '0;
      serial_out <= 1'b0;
    end else begin
      if (strobe_wr) begin
        strb <= strobe_din;
      end
      shreg      <= shreg_next;
      serial_out <= shreg_next[0];
    end
  end

endmodule
